// File: rtl/alu_response_checker.sv
// Response-side checker for the 8-bit ALU: predicts each accepted command's result,
// queues it in order, and scores every returned response against the queue head.
module alu_response_checker #(
  parameter  int DEPTH = 8,
  parameter  int CNT_W = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int PW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  input  logic             rsp_valid,
  input  logic [7:0]       rsp_word,
  input  logic [7:0]       rsp_inp1,
  input  logic             rsp_carry,
  input  logic             rsp_ovf,
  output logic [PW-1:0]    pending,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             mismatch,
  output logic             err_unexpected,
  output logic             first_fail_valid,
  output logic [1:0]       first_fail_op,
  output logic [7:0]       first_fail_a,
  output logic [7:0]       first_fail_b,
  output logic [7:0]       first_fail_word
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERROR} state_t;

  state_t state_q, state_d;

  logic [7:0] entryA_q     [DEPTH];
  logic [7:0] entryB_q     [DEPTH];
  logic [1:0] entryOp_q    [DEPTH];
  logic [7:0] entryWord_q  [DEPTH];
  logic       entryCarry_q [DEPTH];
  logic       entryOvf_q   [DEPTH];

  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0]    pending_q, pending_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] fail_q, fail_d;
  logic             mismatch_q, mismatch_d;
  logic             err_q, err_d;
  logic             ffValid_q, ffValid_d;
  logic [1:0]       ffOp_q, ffOp_d;
  logic [7:0]       ffA_q, ffA_d;
  logic [7:0]       ffB_q, ffB_d;
  logic [7:0]       ffWord_q, ffWord_d;

  logic       pushEn;
  logic       popEn;
  logic       unexpected;
  logic       headMatch;
  logic [8:0] sum9;
  logic [7:0] expWord;
  logic       expCarry;
  logic       expOvf;

  // Readiness depends only on registered occupancy, so a same-cycle pop never frees a slot.
  assign cmd_ready  = (pending_q != PW'(DEPTH));
  assign pushEn     = cmd_valid && cmd_ready;
  assign popEn      = rsp_valid && (pending_q != '0);
  assign unexpected = rsp_valid && (pending_q == '0);

  always_comb begin
    sum9     = '0;
    expWord  = '0;
    expCarry = 1'b0;
    expOvf   = 1'b0;
    case (cmd_op)
      2'd0: begin
        sum9     = {1'b0, cmd_a} + {1'b0, cmd_b};
        expWord  = sum9[7:0];
        expCarry = sum9[8];
        expOvf   = (cmd_a[7] == cmd_b[7]) && (sum9[7] != cmd_a[7]);
      end
      2'd1: begin
        sum9     = {1'b0, cmd_a} + {1'b0, ~cmd_b} + 9'd1;
        expWord  = sum9[7:0];
        expCarry = sum9[8];
        expOvf   = (cmd_a[7] != cmd_b[7]) && (sum9[7] != cmd_a[7]);
      end
      2'd2:    expWord = cmd_a & cmd_b;
      default: expWord = cmd_a | cmd_b;
    endcase
  end

  assign headMatch = (rsp_word  == entryWord_q[rdPtr_q])
                  && (rsp_inp1  == entryA_q[rdPtr_q])
                  && (rsp_carry == entryCarry_q[rdPtr_q])
                  && (rsp_ovf   == entryOvf_q[rdPtr_q]);

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    pending_d  = pending_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    ffValid_d  = ffValid_q;
    ffOp_d     = ffOp_q;
    ffA_d      = ffA_q;
    ffB_d      = ffB_q;
    ffWord_d   = ffWord_q;
    state_d    = state_q;

    if (pushEn) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (popEn)  rdPtr_d = rdPtr_q + PTR_W'(1);

    if (pushEn && !popEn)      pending_d = pending_q + PW'(1);
    else if (!pushEn && popEn) pending_d = pending_q - PW'(1);

    // Counters hold at all-ones instead of wrapping.
    if (popEn) begin
      if (headMatch) begin
        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
      end else begin
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        mismatch_d = 1'b1;
        if (!ffValid_q) begin
          ffValid_d = 1'b1;
          ffOp_d    = entryOp_q[rdPtr_q];
          ffA_d     = entryA_q[rdPtr_q];
          ffB_d     = entryB_q[rdPtr_q];
          ffWord_d  = rsp_word;
        end
      end
    end

    if (unexpected) err_d = 1'b1;

    if (unexpected || state_q == ERROR) state_d = ERROR;
    else if (pending_d != '0)           state_d = ACTIVE;
    else                                state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      pending_q  <= '0;
      pass_q     <= '0;
      fail_q     <= '0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
      ffValid_q  <= 1'b0;
      ffOp_q     <= '0;
      ffA_q      <= '0;
      ffB_q      <= '0;
      ffWord_q   <= '0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      pending_q  <= pending_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
      ffValid_q  <= ffValid_d;
      ffOp_q     <= ffOp_d;
      ffA_q      <= ffA_d;
      ffB_q      <= ffB_d;
      ffWord_q   <= ffWord_d;
    end
  end

  // Queue storage needs no reset: the pointers and occupancy define which slots are live.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      entryA_q[wrPtr_q]     <= cmd_a;
      entryB_q[wrPtr_q]     <= cmd_b;
      entryOp_q[wrPtr_q]    <= cmd_op;
      entryWord_q[wrPtr_q]  <= expWord;
      entryCarry_q[wrPtr_q] <= expCarry;
      entryOvf_q[wrPtr_q]   <= expOvf;
    end
  end

  assign pending          = pending_q;
  assign pass_count       = pass_q;
  assign fail_count       = fail_q;
  assign mismatch         = mismatch_q;
  assign err_unexpected   = err_q;
  assign first_fail_valid = ffValid_q;
  assign first_fail_op    = ffOp_q;
  assign first_fail_a     = ffA_q;
  assign first_fail_b     = ffB_q;
  assign first_fail_word  = ffWord_q;

endmodule

// File: doc/alu_response_checker.md
Name: alu_response_checker

Overview:
Synthesizable response-side companion to the 8-bit register-file/ALU. The operation source drives operand/opcode commands. This block captures each accepted command, computes the expected ALU result, and queues it in order. It then compares every returned ALU response (word, echoed operand 1, carry, overflow) against the queue head and keeps pass/fail statistics plus a first-failure snapshot.

Parameters:
DEPTH, 8, expected-result queue depth (power of 2, >=2)
CNT_W, 16, width of pass/fail counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command issued to the ALU this cycle
cmd_ready  out  1  queue can accept a command (high when pending < DEPTH)
cmd_a  in  8  operand inreg1
cmd_b  in  8  operand inreg2
cmd_op  in  2  opcode: 0 add, 1 sub, 2 and, 3 or
rsp_valid  in  1  ALU response present this cycle
rsp_word  in  8  store_word from ALU
rsp_inp1  in  8  store_inp1 from ALU
rsp_carry  in  1  carry_output from ALU
rsp_ovf  in  1  overflow_output from ALU
pending  out  $clog2(DEPTH+1)  outstanding expected entries
pass_count  out  CNT_W  matching responses
fail_count  out  CNT_W  mismatching responses
mismatch  out  1  one-cycle pulse per failing compare
err_unexpected  out  1  sticky: response arrived with empty queue
first_fail_valid  out  1  sticky: snapshot below is valid
first_fail_op  out  2  opcode of first failing entry
first_fail_a  out  8  cmd_a of first failing entry
first_fail_b  out  8  cmd_b of first failing entry
first_fail_word  out  8  rsp_word received at first failure

Behaviour:
- Reset (rst=1 at edge): pending=0, counters=0, mismatch=0, err_unexpected=0, first_fail_valid=0, all snapshot fields=0, FSM=IDLE, queue pointers=0. Reset mid-operation discards all queued entries.
- Accept: cmd_valid && cmd_ready. Expected result is computed combinationally and pushed at that edge. The entry holds {a, b, op, exp_word, exp_carry, exp_ovf}.
- Expected values, 9-bit arithmetic:
  - add: s = a + b; word = s[7:0]; carry = s[8]; ovf = (a[7]==b[7]) && (word[7]!=a[7]).
  - sub: s = a + ~b + 1; word = s[7:0]; carry = s[8] (1 = no borrow); ovf = (a[7]!=b[7]) && (word[7]!=a[7]).
  - and/or: bitwise; carry = 0; ovf = 0.
  - Expected echo = a.
- Compare: on rsp_valid with pending>0, the head is compared against all four response fields in the same cycle and popped at the edge.
  - All fields equal: pass_count+1.
  - Otherwise: fail_count+1 and mismatch=1 for the following cycle. If first_fail_valid=0, capture the snapshot and set first_fail_valid.
- Counters saturate at all-ones and do not wrap.
- rsp_valid with pending=0: no pop, no counter change, err_unexpected set (sticky until rst). This applies even if a command is accepted in the same cycle; that command is still pushed.
- Simultaneous push and pop with 0<pending<DEPTH: pending is unchanged and both operations take effect.
- Full: cmd_ready=0. A cmd_valid while full is ignored (not queued, no error). A same-cycle pop does not enable the push; cmd_ready is not combinationally dependent on rsp_valid.
- Read/write pointers wrap modulo DEPTH.
- FSM:
  - IDLE (pending=0) -> ACTIVE on accept.
  - ACTIVE -> IDLE when the last entry pops with no same-cycle push.
  - Any state -> ERROR when err_unexpected sets.
  - ERROR keeps compare and count behaviour identical to ACTIVE/IDLE (pending tracks normally); only rst exits.
- Latency:
  - pending and counters update 1 cycle after the triggering edge inputs.
  - No limit on cycles between command and response; ordering is strictly FIFO.

Test Plan:
- Reset, then push add a=1,b=1 and respond word=2,inp1=1,c=0,v=0 -> pass_count=1, fail_count=0, pending back to 0, mismatch never high.
- Push add 127,10; sub 1,1; and 127,10; or 127,10, then respond {0x89,127,0,1}, {0x00,1,1,0}, {0x0A,127,0,0}, {0x7F,127,0,0} -> pass_count=4, pending 4->0 one per response.
- Push sub 12,0xF6 and respond word=0x16,c=0,v=1 -> fail_count=1, mismatch pulse 1 cycle, first_fail = {op=1, a=12, b=0xF6, word=0x16}. A later failing and 12,0xF6 (expected 0x04) leaves the snapshot unchanged.
- Push 8 commands with no responses -> pending=8, cmd_ready=0, a 9th cmd_valid is ignored. Then assert rsp_valid and cmd_valid in the same cycle -> pending=7 and no push.
- rsp_valid with pending=0 (and again with a same-cycle accept) -> err_unexpected=1, counters unchanged, FSM=ERROR, pending=1 in the second case.
- Assert rst with pending=5 and fail_count=2 -> next cycle all outputs 0, cmd_ready=1, FSM=IDLE.
